// File: rtl/x16_bus_pkg.sv
// x16_bus_pkg: register map and STATUS/CONTROL bit positions for x16_bus_mailbox.
package x16_bus_pkg;
  localparam logic [4:0] REG_TXDATA  = 5'h00;
  localparam logic [4:0] REG_RXDATA  = 5'h01;
  localparam logic [4:0] REG_STATUS  = 5'h02;
  localparam logic [4:0] REG_CONTROL = 5'h03;
  localparam int ST_RX_AVAIL   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_UNDERFLOW  = 2;
  localparam int ST_OVERFLOW   = 3;
  localparam int CTL_FLUSH_IN  = 0;
  localparam int CTL_FLUSH_OUT = 1;
endpackage

// File: rtl/x16_sync_fifo.sv
// x16_sync_fifo: byte FIFO with push/pop/flush; flush wins over same-cycle push and pop.
module x16_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [7:0]             din_i,
  output logic [7:0]             dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  always_comb cnt_d = do_push && !do_pop ? cnt_q + 1'b1 : !do_push && do_pop ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= do_push ? wp_q + 1'b1 : wp_q;
      rp_q  <= do_pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/x16_bus_mailbox.sv
// x16_bus_mailbox: X16 bus target bridging register accesses to outbound/inbound byte FIFOs.
// Define X16_BUS_MAILBOX_WAIT_EN to stall (RDY low) on empty reads / full writes up to WAIT_MAX cycles.
module x16_bus_mailbox
  import x16_bus_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic       PHI2,
  input  logic       RST,
  input  logic       CS,
  input  logic       RWB,
  input  logic [4:0] addr,
  inout  wire  [7:0] data,
  output wire        RDY,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);
  logic rd, wr, rx_rd, tx_wr, st_wr, ctl_wr, stall, commit, hazard;
  logic in_full, in_empty, out_full, out_empty;
  logic unf_q, unf_d, ovf_q, ovf_d;
  logic [7:0] in_head, status, rd_data;
  logic [$clog2(DEPTH):0] unused_in_cnt, unused_out_cnt;
  assign rd     = CS && RWB;
  assign wr     = CS && !RWB;
  assign rx_rd  = rd && addr == REG_RXDATA;
  assign tx_wr  = wr && addr == REG_TXDATA;
  assign st_wr  = wr && addr == REG_STATUS;
  assign ctl_wr = wr && addr == REG_CONTROL;
  assign hazard = (rx_rd && in_empty) || (tx_wr && out_full);
  assign commit = CS && !stall;
`ifdef X16_BUS_MAILBOX_WAIT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  assign stall       = hazard && stall_cnt_q < 16'(WAIT_MAX);
  assign stall_cnt_d = stall ? stall_cnt_q + 16'd1 : '0;
  always_ff @(posedge PHI2) stall_cnt_q <= RST ? '0 : stall_cnt_d;
  assign RDY = stall && !RST ? 1'b0 : 1'bz;
`else
  logic [15:0] unused_wait;
  assign unused_wait = 16'(WAIT_MAX);
  assign stall = 1'b0;
  assign RDY   = 1'bz;
`endif
  x16_sync_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk(PHI2), .rst(RST),
    .push_i(commit && tx_wr), .pop_i(out_ready),
    .flush_i(commit && ctl_wr && data[CTL_FLUSH_OUT]), .din_i(data),
    .dout_o(out_data), .count_o(unused_out_cnt), .full_o(out_full), .empty_o(out_empty)
  );
  x16_sync_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clk(PHI2), .rst(RST),
    .push_i(in_valid), .pop_i(commit && rx_rd),
    .flush_i(commit && ctl_wr && data[CTL_FLUSH_IN]), .din_i(in_data),
    .dout_o(in_head), .count_o(unused_in_cnt), .full_o(in_full), .empty_o(in_empty)
  );
  assign out_valid = !out_empty;
  assign in_ready  = !in_full;
  assign status    = {4'b0, ovf_q, unf_q, out_full, !in_empty};
  always_comb begin
    rd_data = addr == REG_RXDATA ? (in_empty ? 8'h00 : in_head) : addr == REG_STATUS ? status : 8'h00;
    unf_d = (commit && rx_rd && in_empty) || (unf_q && !(commit && st_wr && data[ST_UNDERFLOW]));
    ovf_d = (commit && tx_wr && out_full) || (ovf_q && !(commit && st_wr && data[ST_OVERFLOW]));
  end
  assign data = rd ? rd_data : 8'bz;
  always_ff @(posedge PHI2) begin
    unf_q <= RST ? 1'b0 : unf_d;
    ovf_q <= RST ? 1'b0 : ovf_d;
  end
endmodule

// File: tb/tb_x16_bus_mailbox.sv
// tb_x16_bus_mailbox: directed self-checking bench; wait-state cases run only with X16_BUS_MAILBOX_WAIT_EN.
module tb_x16_bus_mailbox;
  logic clk = 0, rst = 1, cs = 0, rwb = 1, drv = 0, out_ready = 0, in_valid = 0;
  logic [4:0] addr = 0;
  logic [7:0] wdata = 0, in_data = 0, rdv;
  logic [7:0] out_data;
  logic out_valid, in_ready;
  wire [7:0] data;
  wire rdy;
  int checks = 0, errors = 0;
  pullup (rdy);
  assign data = drv ? wdata : 8'bz;
  always #5 clk = ~clk;
  x16_bus_mailbox #(.DEPTH(16), .WAIT_MAX(4)) dut (
    .PHI2(clk), .RST(rst), .CS(cs), .RWB(rwb), .addr(addr), .data(data), .RDY(rdy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [4:0] a, input logic [7:0] d);
    cs = 1; rwb = !w; drv = w; addr = a; wdata = d;
    @(negedge clk) rdv = data;
    @(posedge clk) #1;
  endtask
  task automatic idle();
    cs = 0; drv = 0; rwb = 1;
  endtask
  task automatic tick();
    @(posedge clk) #1;
  endtask
  task automatic rd_status(input string tag, input logic [7:0] exp);
    bus(0, 5'h02, 0); idle(); chk(tag, rdv, exp);
  endtask
  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    chk("rst_rdy", {7'b0, rdy}, 8'h01);
    @(posedge clk) #1 rst = 0;
    rd_status("rst_status", 8'h00);
    // back-to-back writes then local drain
    bus(1, 5'h00, 8'hA5); bus(1, 5'h00, 8'h5A); idle();
    chk("tx_head0", out_data, 8'hA5);
    chk("tx_valid", {7'b0, out_valid}, 8'h01);
    out_ready = 1; tick();
    chk("tx_head1", out_data, 8'h5A);
    tick(); out_ready = 0;
    chk("tx_empty", {7'b0, out_valid}, 8'h00);
    // local push, bus read
    in_valid = 1; in_data = 8'h3C; tick(); in_valid = 0;
    rd_status("rx_avail", 8'h01);
    bus(0, 5'h01, 0); idle(); chk("rx_data", rdv, 8'h3C);
    rd_status("rx_drained", 8'h00);
    bus(0, 5'h03, 0); idle(); chk("ctl_reads0", rdv, 8'h00);
    bus(0, 5'h1F, 0); idle(); chk("other_reads0", rdv, 8'h00);
`ifndef X16_BUS_MAILBOX_WAIT_EN
    bus(0, 5'h01, 0); idle(); chk("unf_data", rdv, 8'h00);
    rd_status("unf_status", 8'h04);
    bus(1, 5'h02, 8'h04); idle();
    rd_status("unf_clear", 8'h00);
    for (int i = 0; i < 16; i++) bus(1, 5'h00, 8'(i * 17 + 1));
    bus(1, 5'h00, 8'hEE); idle();
    rd_status("ovf_status", 8'h0A);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), out_data, 8'(i * 17 + 1));
      tick();
    end
    out_ready = 0;
    chk("drain_empty", {7'b0, out_valid}, 8'h00);
    bus(1, 5'h02, 8'h08); idle();
    rd_status("ovf_clear", 8'h00);
`endif
    // simultaneous push and pop on outbound
    bus(1, 5'h00, 8'h11); idle();
    out_ready = 1; bus(1, 5'h00, 8'h77); idle(); out_ready = 0;
    chk("pushpop_data", out_data, 8'h77);
    chk("pushpop_valid", {7'b0, out_valid}, 8'h01);
    bus(1, 5'h03, 8'h02); idle();
    chk("flush_out", {7'b0, out_valid}, 8'h00);
    // fill inbound, then flush with a colliding local push
    in_valid = 1;
    for (int i = 0; i < 16; i++) begin in_data = 8'(i + 8'h40); tick(); end
    in_valid = 0;
    chk("in_full", {7'b0, in_ready}, 8'h00);
    bus(0, 5'h01, 0); idle(); chk("in_head", rdv, 8'h40);
    in_valid = 1; in_data = 8'h55;
    bus(1, 5'h03, 8'h01); idle(); in_valid = 0;
    chk("flush_in_ready", {7'b0, in_ready}, 8'h01);
    rd_status("flush_in_status", 8'h00);
`ifdef X16_BUS_MAILBOX_WAIT_EN
    cs = 1; rwb = 1; addr = 5'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) chk($sformatf("stall%0d", i), {7'b0, rdy}, 8'h00);
      @(posedge clk) #1;
    end
    @(negedge clk);
    chk("stall_release", {7'b0, rdy}, 8'h01);
    chk("stall_data", data, 8'h00);
    @(posedge clk) #1 idle();
    rd_status("stall_unf", 8'h04);
    bus(1, 5'h02, 8'h04); idle();
    cs = 1; rwb = 1; addr = 5'h01;
    tick(); tick();
    in_valid = 1; in_data = 8'h99;
    @(negedge clk) chk("stall2_low", {7'b0, rdy}, 8'h00);
    @(posedge clk) #1 in_valid = 0;
    @(negedge clk);
    chk("stall2_release", {7'b0, rdy}, 8'h01);
    chk("stall2_data", data, 8'h99);
    @(posedge clk) #1 idle();
    rd_status("stall2_status", 8'h00);
    bus(1, 5'h00, 8'h21); idle();
    cs = 1; rwb = 1; addr = 5'h01;
    tick();
    rst = 1;
    @(negedge clk) chk("rst_stall_rdy", {7'b0, rdy}, 8'h01);
    @(posedge clk) #1 rst = 0; idle();
    chk("rst_stall_out", {7'b0, out_valid}, 8'h00);
    chk("rst_stall_in", {7'b0, in_ready}, 8'h01);
    rd_status("rst_stall_status", 8'h00);
`else
    in_valid = 1; in_data = 8'h12; tick(); in_valid = 0;
    bus(1, 5'h00, 8'h34); idle();
    rst = 1; tick(); rst = 0;
    chk("rst_out", {7'b0, out_valid}, 8'h00);
    chk("rst_in", {7'b0, in_ready}, 8'h01);
    rd_status("rst_status2", 8'h00);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
